dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Initiator side of the data-memory port: accepts one load/store request at a time from the execute-memory stage, sequences one or two 16-bit word accesses to `data_memory`, and returns a response. 32-bit operations (PC push/pop for CALL/RET/interrupt) are split into two consecutive word accesses. While a request is in flight the pipeline is stalled via `o_busy`.

## Interface
- `ADDR_BITS`, default 12: implemented word-address bits; depth is 4096 words.
- `DATA_W`, default 16: memory word width.
- `i_clk`, in, 1: clock. All state changes on the rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_req_valid`, in, 1: request present.
- `i_req_op`, in, 2: `00` LOAD16, `01` STORE16, `10` LOAD32, `11` STORE32.
- `i_req_address`, in, 16: word address of the first word.
- `i_req_write_data`, in, 32: store data. STORE16 uses `[15:0]`.
- `o_req_ready`, out, 1: request accepted on an edge where valid and ready are both high.
- `o_resp_valid`, out, 1: one-cycle completion pulse, for loads and stores.
- `o_resp_data`, out, 32: load result; 0 for stores.
- `o_addr_err`, out, 1: valid with `o_resp_valid`; some accessed address had bits `[15:ADDR_BITS]` nonzero.
- `o_busy`, out, 1: state is not IDLE. Pipeline stall.
- `o_mem_address`, out, 16: to `data_memory` `i_address`.
- `o_mem_write_data`, out, 16: to `i_write_data`.
- `o_mem_read`, out, 1: to `i_memory_read`.
- `o_mem_write`, out, 1: to `i_memory_write`.
- `i_mem_read_data`, in, 16: from `o_read_data`. Registered in memory; valid the cycle after the read is issued.

## Operation
- States are IDLE, FIRST, SECOND and RESP.
- **IDLE**
  - `o_req_ready`=1, memory strobes 0.
  - On accept, latch op, address and write data, then go to FIRST.
- **FIRST**: drive word 0.
  - Address is `{0, addr[ADDR_BITS-1:0]}`.
  - Read strobe for loads. Write strobe for stores, with data `wdata[31:16]` for STORE32 and `wdata[15:0]` for STORE16.
  - Next state is SECOND for 32-bit ops, else RESP.
- **SECOND**: drive word 1.
  - Address is `addr+1` masked to `ADDR_BITS`, so `0x0FFF` wraps to `0x0000`. Write data is `wdata[15:0]`.
  - For LOAD32, capture `i_mem_read_data` (word 0) into the high register this cycle.
  - Next state is RESP.
- **RESP**
  - `o_resp_valid`=1.
  - `o_resp_data` is `{16'h0, i_mem_read_data}` for LOAD16, `{hi, i_mem_read_data}` for LOAD32, and 0 for stores.
  - Next state is IDLE.
- Word order: the high half is at the lower address (big-endian word order).
- `o_addr_err` is set at accept if `addr[15:ADDR_BITS]`≠0. For 32-bit ops it is also set if the unmasked `addr+1` overflows that range. The access is still performed with the masked address.
- `o_mem_address` holds its last value outside FIRST/SECOND.
- `o_mem_write_data` holds its last value outside FIRST/SECOND.
- `i_req_*` is ignored when not ready. There is no queuing.

## Timing
- Accept at edge k. FIRST occupies cycle k+1.
- Response: cycle k+2 for 16-bit ops, k+3 for 32-bit ops.
- Next accept can happen at the edge ending RESP+1 (the IDLE cycle). Throughput is one op per 3 cycles (16-bit) or 4 cycles (32-bit).
- Reset values, all 0:
  - outputs `o_resp_valid`, `o_resp_data`, `o_addr_err`, `o_busy`, `o_mem_*`;
  - internal registers.
- State resets to IDLE.
- `o_req_ready` is 0 while `i_reset` is high and 1 in the first cycle after.
- Reset mid-operation: return to IDLE with no response.
  - A write already issued in FIRST stays in memory.
  - The SECOND write of a STORE32 is not performed.
- `o_busy` is high in FIRST, SECOND and RESP.
- `i_req_valid` held high continuously: a new accept happens on each IDLE edge; the request is never accepted twice.

## Structure
- Shared package:
  - op-code constants (`OP_LOAD16`, `OP_STORE16`, `OP_LOAD32`, `OP_STORE32`);
  - state encoding;
  - `ADDR_BITS`/`DATA_W` defaults, shared with `data_memory`.
- Single flat module, no sub-module.
- The parent instantiates `data_memory` and wires `o_mem_*`/`i_mem_read_data` to it.

## Test plan
- **STORE16 then LOAD16**
  - Stimulus: STORE16 `0x0010` ← `0x0A00`, then LOAD16 `0x0010`.
  - Response: write strobe in the single FIRST cycle; load resp at k+2 with `0x00000A00`; `o_addr_err`=0.
- **STORE32 then LOAD32**
  - Stimulus: STORE32 `0x0200` ← `0x12345678`, then LOAD32 `0x0200`.
  - Response: mem[`0x200`]=`0x1234`, mem[`0x201`]=`0x5678`; resp `0x12345678` at k+3.
- **Wrap and range error**
  - Stimulus: STORE32 at `0x0FFF` ← `0xAAAA5555`.
  - Response: writes go to `0x0FFF`/`0x0000`; `o_addr_err`=1.
  - Stimulus: LOAD16 at `0x1005`.
  - Response: reads `0x0005`; `o_addr_err`=1.
- **Back-to-back requests**
  - Stimulus: `i_req_valid` held high with 3 queued LOAD16s.
  - Response: accepts 3 cycles apart, each `o_resp_valid` a single-cycle pulse, `o_busy` low only in IDLE cycles.
- **Reset mid-operation**
  - Stimulus: assert `i_reset` during SECOND of STORE32 `0x0300` ← `0xBEEFCAFE`.
  - Response: mem[`0x300`]=`0xBEEF`; mem[`0x301`] unchanged; no `o_resp_valid`; all outputs 0 next cycle; `o_req_ready`=1 after release.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller and its data_memory partner.
package dmem_access_ctrl_pkg;

    localparam int unsigned ADDR_BITS = 12;
    localparam int unsigned DATA_W    = 16;

    localparam logic [1:0] OP_LOAD16  = 2'b00;
    localparam logic [1:0] OP_STORE16 = 2'b01;
    localparam logic [1:0] OP_LOAD32  = 2'b10;
    localparam logic [1:0] OP_STORE32 = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StSecond,
        StResp
    } state_e;

    function automatic logic op_is32(logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_store(logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory signals of the access controller, seen from either side.
interface dmem_access_ctrl_if;
    import dmem_access_ctrl_pkg::*;

    logic              i_req_valid;
    logic [1:0]        i_req_op;
    logic [15:0]       i_req_address;
    logic [31:0]       i_req_write_data;
    logic              o_req_ready;
    logic              o_resp_valid;
    logic [31:0]       o_resp_data;
    logic              o_addr_err;
    logic              o_busy;
    logic [15:0]       o_mem_address;
    logic [DATA_W-1:0] o_mem_write_data;
    logic              o_mem_read;
    logic              o_mem_write;
    logic [DATA_W-1:0] i_mem_read_data;

    modport slave (
        input  i_req_valid, i_req_op, i_req_address, i_req_write_data, i_mem_read_data,
        output o_req_ready, o_resp_valid, o_resp_data, o_addr_err, o_busy,
        output o_mem_address, o_mem_write_data, o_mem_read, o_mem_write
    );

    modport master (
        output i_req_valid, i_req_op, i_req_address, i_req_write_data, i_mem_read_data,
        input  o_req_ready, o_resp_valid, o_resp_data, o_addr_err, o_busy,
        input  o_mem_address, o_mem_write_data, o_mem_read, o_mem_write
    );

endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences one or two 16-bit word accesses per load/store request, stalling the pipeline
// while a request is in flight. 32-bit values are stored high word first.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_BITS = dmem_access_ctrl_pkg::ADDR_BITS,
    parameter int unsigned DATA_W    = dmem_access_ctrl_pkg::DATA_W
) (
    input logic               i_clk,
    input logic               i_reset,
    dmem_access_ctrl_if.slave bus
);
    import dmem_access_ctrl_pkg::*;

    localparam logic [15:0] AddrMask = 16'((32'd1 << ADDR_BITS) - 32'd1);

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [15:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [DATA_W-1:0] hi_q;
    logic              err_q;
    logic [15:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              accept;
    logic              err_d;
    logic [16:0]       addr_inc;

    assign accept   = bus.i_req_valid && bus.o_req_ready;
    assign addr_inc = {1'b0, bus.i_req_address} + 17'd1;
    // Error if the first word, or for 32-bit ops the unmasked second word, leaves the range.
    assign err_d    = (|(bus.i_req_address >> ADDR_BITS)) ||
                      (op_is32(bus.i_req_op) && (|(addr_inc >> ADDR_BITS)));

    always_comb begin
        state_d          = state_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        bus.o_req_ready  = 1'b0;
        bus.o_mem_read   = 1'b0;
        bus.o_mem_write  = 1'b0;
        bus.o_resp_valid = 1'b0;
        bus.o_resp_data  = '0;
        bus.o_addr_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.o_req_ready = 1'b1;
                if (bus.i_req_valid) state_d = StFirst;
            end
            StFirst: begin
                mem_addr_d      = addr_q & AddrMask;
                mem_wdata_d     = op_is32(op_q) ? wdata_q[31:16] : wdata_q[15:0];
                bus.o_mem_read  = !op_is_store(op_q);
                bus.o_mem_write = op_is_store(op_q);
                state_d         = op_is32(op_q) ? StSecond : StResp;
            end
            StSecond: begin
                mem_addr_d      = (addr_q + 16'd1) & AddrMask;
                mem_wdata_d     = wdata_q[15:0];
                bus.o_mem_read  = !op_is_store(op_q);
                bus.o_mem_write = op_is_store(op_q);
                state_d         = StResp;
            end
            StResp: begin
                bus.o_resp_valid = 1'b1;
                bus.o_addr_err   = err_q;
                if (!op_is_store(op_q)) begin
                    bus.o_resp_data = {(op_is32(op_q) ? hi_q : '0), bus.i_mem_read_data};
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset suppresses any strobe so an interrupted STORE32 never writes its second word.
        if (i_reset) begin
            bus.o_req_ready  = 1'b0;
            bus.o_mem_read   = 1'b0;
            bus.o_mem_write  = 1'b0;
            bus.o_resp_valid = 1'b0;
            bus.o_resp_data  = '0;
            bus.o_addr_err   = 1'b0;
        end
    end

    assign bus.o_busy           = (state_q != StIdle);
    assign bus.o_mem_address    = mem_addr_d;
    assign bus.o_mem_write_data = mem_wdata_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hi_q        <= '0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (accept) begin
                op_q    <= bus.i_req_op;
                addr_q  <= bus.i_req_address;
                wdata_q <= bus.i_req_write_data;
                err_q   <= err_d;
            end
            if (state_q == StSecond && op_q == OP_LOAD32) hi_q <= bus.i_mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a request-level model predicts every cycle of outputs,
// and literal expectations pin the results of the directed scenarios.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    dmem_access_ctrl_if bus();

    dmem_access_ctrl dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in for data_memory: synchronous write, registered read.
    logic [15:0] mem [4096];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'hC000 + 16'(i);
            mem_init <= 1'b1;
        end else begin
            if (bus.o_mem_write) mem[bus.o_mem_address[11:0]] <= bus.o_mem_write_data;
        end
        if (bus.o_mem_read) bus.i_mem_read_data <= mem[bus.o_mem_address[11:0]];
    end

    // Request-level model: each accept expands into the cycles it must produce.
    logic [15:0] ref_mem [4096];
    bit   ref_init = 1'b0;
    exp_t sched[$];
    logic [15:0] last_addr = '0, last_wdata = '0;
    int cyc = 0, acc_cnt = 0, resp_cnt = 0;
    int acc_hist[$];
    int last_resp_cyc = 0;
    logic [31:0] last_resp_data;
    logic last_resp_err;

    always @(negedge clk) begin : model
        exp_t e, n;
        int unsigned ai;
        logic is32, isst;
        logic [15:0] a0, a1, wd0;
        if (!ref_init) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = 16'hC000 + 16'(i);
            ref_init = 1'b1;
        end
        cyc++;
        e = '0;
        if (sched.size() > 0) e = sched.pop_front();
        if (rst) begin
            chk("rst_ready", {31'b0, bus.o_req_ready}, 32'd0);
            chk("rst_strobes", {30'b0, bus.o_mem_read, bus.o_mem_write}, 32'd0);
            chk("rst_resp_valid", {31'b0, bus.o_resp_valid}, 32'd0);
            sched.delete();
            last_addr = '0;
            last_wdata = '0;
        end else begin
            if (!e.rd && !e.wr) begin
                e.addr = last_addr;
                if (!e.busy || !e.rv) e.wdata = (e.busy) ? e.wdata : last_wdata;
            end
            chk("busy", {31'b0, bus.o_busy}, {31'b0, e.busy});
            chk("ready", {31'b0, bus.o_req_ready}, {31'b0, !e.busy});
            chk("mem_read", {31'b0, bus.o_mem_read}, {31'b0, e.rd});
            chk("mem_write", {31'b0, bus.o_mem_write}, {31'b0, e.wr});
            chk("mem_address", {16'b0, bus.o_mem_address}, {16'b0, e.addr});
            if (e.wr || !e.busy) chk("mem_wdata", {16'b0, bus.o_mem_write_data}, {16'b0, e.wdata});
            chk("resp_valid", {31'b0, bus.o_resp_valid}, {31'b0, e.rv});
            if (e.rv) begin
                chk("resp_data", bus.o_resp_data, e.rdata);
                chk("addr_err", {31'b0, bus.o_addr_err}, {31'b0, e.err});
            end
            if (e.wr) ref_mem[e.addr[11:0]] = e.wdata;
            if (e.rd || e.wr) begin
                last_addr = e.addr;
                last_wdata = e.wdata;
            end
            if (bus.o_resp_valid) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                last_resp_data = bus.o_resp_data;
                last_resp_err = bus.o_addr_err;
            end
            if (!e.busy && bus.i_req_valid) begin
                acc_cnt++;
                acc_hist.push_back(cyc);
                ai = bus.i_req_address;
                is32 = bus.i_req_op[1];
                isst = bus.i_req_op[0];
                a0 = bus.i_req_address & 16'h0FFF;
                a1 = (bus.i_req_address + 16'd1) & 16'h0FFF;
                wd0 = bus.i_req_write_data[15:0];
                n = '0;
                n.busy = 1'b1;
                n.rd = !isst;
                n.wr = isst;
                n.addr = a0;
                n.wdata = is32 ? bus.i_req_write_data[31:16] : wd0;
                sched.push_back(n);
                if (is32) begin
                    n.addr = a1;
                    n.wdata = wd0;
                    sched.push_back(n);
                end
                n = '0;
                n.busy = 1'b1;
                n.rv = 1'b1;
                n.err = (ai >= 4096) || (is32 && ai + 1 >= 4096);
                if (!isst) n.rdata = is32 ? {ref_mem[a0], ref_mem[a1]} : {16'h0, ref_mem[a0]};
                sched.push_back(n);
            end
        end
    end

    int rc0;

    task automatic wait_acc(input int target);
        int k;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (acc_cnt >= target) break;
        end
        if (k == 20) chk("accept_timeout", acc_cnt, target);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [31:0] wd);
        int n0;
        @(posedge clk);
        #2;
        rc0 = resp_cnt;
        n0 = acc_cnt;
        bus.i_req_valid = 1'b1;
        bus.i_req_op = op;
        bus.i_req_address = a;
        bus.i_req_write_data = wd;
        wait_acc(n0 + 1);
        bus.i_req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int k;
        for (k = 0; k < 20; k++) begin
            if (resp_cnt != rc0) break;
            @(posedge clk);
            #2;
        end
        if (k == 20) chk("resp_timeout", resp_cnt, rc0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, r0;
        bus.i_req_valid = 1'b0;
        bus.i_req_op = '0;
        bus.i_req_address = '0;
        bus.i_req_write_data = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_ready", {31'b0, bus.o_req_ready}, 32'd1);
        chk("post_rst_busy", {31'b0, bus.o_busy}, 32'd0);
        chk("post_rst_addr", {16'b0, bus.o_mem_address}, 32'd0);

        do_op(OP_STORE16, 16'h0010, 32'h0000_0A00);
        wait_resp();
        chk("st16_err", {31'b0, last_resp_err}, 32'd0);
        chk("st16_data", last_resp_data, 32'd0);
        do_op(OP_LOAD16, 16'h0010, 32'h0);
        wait_resp();
        chk("ld16_data", last_resp_data, 32'h0000_0A00);
        chk("ld16_latency", last_resp_cyc - acc_hist[acc_hist.size() - 1], 32'd2);

        do_op(OP_STORE32, 16'h0200, 32'h1234_5678);
        wait_resp();
        @(posedge clk);
        #2;
        chk("st32_mem200", {16'b0, mem[12'h200]}, 32'h1234);
        chk("st32_mem201", {16'b0, mem[12'h201]}, 32'h5678);
        do_op(OP_LOAD32, 16'h0200, 32'h0);
        wait_resp();
        chk("ld32_data", last_resp_data, 32'h1234_5678);
        chk("ld32_latency", last_resp_cyc - acc_hist[acc_hist.size() - 1], 32'd3);

        do_op(OP_STORE32, 16'h0FFF, 32'hAAAA_5555);
        wait_resp();
        chk("wrap_err", {31'b0, last_resp_err}, 32'd1);
        @(posedge clk);
        #2;
        chk("wrap_memfff", {16'b0, mem[12'hFFF]}, 32'hAAAA);
        chk("wrap_mem000", {16'b0, mem[12'h000]}, 32'h5555);
        do_op(OP_LOAD16, 16'h1005, 32'h0);
        wait_resp();
        chk("range_err", {31'b0, last_resp_err}, 32'd1);
        chk("range_data", last_resp_data, 32'h0000_C005);

        // Valid held high across three loads; the address changes once each is taken.
        @(posedge clk);
        #2;
        n0 = acc_cnt;
        bus.i_req_valid = 1'b1;
        bus.i_req_op = OP_LOAD16;
        bus.i_req_address = 16'h0200;
        wait_acc(n0 + 1);
        bus.i_req_address = 16'h0201;
        wait_acc(n0 + 2);
        bus.i_req_address = 16'h0005;
        wait_acc(n0 + 3);
        bus.i_req_valid = 1'b0;
        chk("b2b_gap1", acc_hist[n0 + 1] - acc_hist[n0], 32'd3);
        chk("b2b_gap2", acc_hist[n0 + 2] - acc_hist[n0 + 1], 32'd3);
        repeat (4) @(posedge clk);
        #2;
        chk("b2b_count", acc_cnt - n0, 32'd3);
        chk("b2b_last_data", last_resp_data, 32'h0000_C005);

        // Reset lands in the SECOND cycle of a STORE32.
        do_op(OP_STORE32, 16'h0300, 32'hBEEF_CAFE);
        r0 = resp_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", {31'b0, bus.o_busy}, 32'd0);
        chk("mid_rst_resp", {31'b0, bus.o_resp_valid}, 32'd0);
        chk("mid_rst_strobes", {30'b0, bus.o_mem_read, bus.o_mem_write}, 32'd0);
        chk("mid_rst_addr", {16'b0, bus.o_mem_address}, 32'd0);
        chk("mid_rst_wdata", {16'b0, bus.o_mem_write_data}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.o_req_ready}, 32'd1);
        chk("mid_rst_mem300", {16'b0, mem[12'h300]}, 32'hBEEF);
        chk("mid_rst_mem301", {16'b0, mem[12'h301]}, 32'hC301);
        repeat (3) @(posedge clk);
        #2;
        chk("mid_rst_no_resp", resp_cnt, r0);
        do_op(OP_LOAD32, 16'h0300, 32'h0);
        wait_resp();
        chk("post_rst_ld32", last_resp_data, 32'hBEEF_C301);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
